// File: rtl/sram_rw_port_ctrl.sv
// Requester-side controller for a 1-cycle-latency single-port SRAM (RW0 port):
// optional zero-fill after reset, credit-gated request acceptance and an in-order response queue.
module sram_rw_port_ctrl #(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 36,
  parameter int MASK_W        = 6,
  parameter int RESP_DEPTH    = 3,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              RW0_clk,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(RESP_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RESP_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_reg, state_next;
  logic              started_reg;
  logic [ADDR_W-1:0] init_cnt_reg;
  logic              inflight_reg;
  logic [CNT_W-1:0]  occ_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [DATA_W-1:0] q_mem [RESP_DEPTH];

  logic [CNT_W:0] credit_used;
  logic           accept, rd_accept, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign RW0_clk = clock;

  // started_reg keeps every output quiet in the first cycle after reset release
  assign init_done   = (state_reg == ST_RUN) && started_reg;
  assign credit_used = {1'b0, occ_reg} + {{CNT_W{1'b0}}, inflight_reg};
  assign req_ready   = init_done && (credit_used < DEPTH_C);
  assign accept      = req_valid && req_ready;
  assign rd_accept   = accept && !req_write;
  assign push        = inflight_reg;
  assign pop         = resp_valid && resp_ready;
  assign resp_valid  = (occ_reg != '0);
  assign resp_rdata  = q_mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if (INIT_ON_RESET) state_reg <= ST_INIT;
      else               state_reg <= ST_RUN;
      started_reg  <= 1'b0;
      init_cnt_reg <= '0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      started_reg  <= 1'b1;
      inflight_reg <= rd_accept;
      if (state_reg == ST_INIT && started_reg) init_cnt_reg <= init_cnt_reg + ADDR_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    RW0_en     = 1'b0;
    RW0_wmode  = 1'b0;
    RW0_addr   = '0;
    RW0_wmask  = req_wmask;
    RW0_wdata  = req_wdata;
    if (state_reg == ST_INIT) begin
      RW0_en    = started_reg;
      RW0_wmode = started_reg;
      RW0_addr  = init_cnt_reg;
      RW0_wmask = '1;
      RW0_wdata = '0;
      if (started_reg && init_cnt_reg == LAST_ADDR) state_next = ST_RUN;
    end else if (accept) begin
      RW0_en    = 1'b1;
      RW0_wmode = req_write;
      RW0_addr  = req_addr;
    end
  end

  // Response queue: RW0_rdata is captured in the cycle after each read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) q_mem[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        q_mem[wr_ptr_reg] <= RW0_rdata;
        wr_ptr_reg        <= ptr_inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + CNT_W'(1);
        2'b01:   occ_reg <= occ_reg - CNT_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule
